// File: rtl/hamming74_serial_encoder_pkg.sv
// Shared types, widths and the Hamming(7,4) encode function for the serial encoder.
// HAMMING_SECDED_EN widens the transmitted codeword with an overall parity bit.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int H74_W  = 7;
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = 8;
`else
  localparam int CW_W = 7;
`endif
  localparam int BITS_LEFT_W = $clog2(CW_W + 1);

  typedef logic [DATA_W-1:0]      nibble_t;
  typedef logic [H74_W-1:0]       h74_cw_t;
  typedef logic [CW_W-1:0]        cw_t;
  typedef logic [BITS_LEFT_W-1:0] bits_left_t;

  // Codeword layout is {p1,p2,d1,p3,d2,d3,d4}, with d1 taken from the nibble MSB.
  function automatic h74_cw_t hamming74_encode(input nibble_t d);
    logic d1, d2, d3, d4;
    logic p1, p2, p3;
    d1 = d[3];
    d2 = d[2];
    d3 = d[1];
    d4 = d[0];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p3 = d2 ^ d3 ^ d4;
    return {p1, p2, d1, p3, d2, d3, d4};
  endfunction

endpackage

// File: rtl/hamming74_serial_encoder_if.sv
// Bit-serial link bundle: input handshake from the source and the codeword stream to the channel.
interface hamming74_serial_encoder_if;

  logic s_in;
  logic in_valid;
  logic in_ready;
  logic s_out;
  logic out_valid;
  logic cw_start;

  modport master (
    output s_in,
    output in_valid,
    input  in_ready,
    input  s_out,
    input  out_valid,
    input  cw_start
  );

  modport slave (
    input  s_in,
    input  in_valid,
    output in_ready,
    output s_out,
    output out_valid,
    output cw_start
  );

endinterface

// File: rtl/hamming74_serial_encoder_enc.sv
// Combinational nibble -> codeword encoder; HAMMING_SECDED_EN appends overall parity as the LSB.
module hamming74_enc
  import hamming_pkg::*;
(
  input  nibble_t nibble,
  output cw_t     cw
);

  h74_cw_t h74;

  // NOTE: continuous assigns have no hold path, so this logic can never infer a latch.
  assign h74 = hamming74_encode(nibble);

`ifdef HAMMING_SECDED_EN
  assign cw = {h74, ^h74};
`else
  assign cw = h74;
`endif

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial-in/serial-out Hamming(7,4) encoder: nibble assembly, encode, MSB-first serializer.
// Build option HAMMING_SECDED_EN sends an 8th overall-parity bit after each codeword.
module hamming74_serial_encoder
  import hamming_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
)
(
  input  logic                        clk,
  input  logic                        reset,
  hamming74_serial_encoder_if.slave   bus
);

  nibble_t    nibble_q;
  logic [1:0] cnt_q;
  logic       nibble_full_q;
  cw_t        shreg_q;
  bits_left_t bits_left_q;
  cw_t        cw;
  logic       accept;
  logic       load;
  logic       busy;

  assign accept = bus.in_valid && !nibble_full_q;
  // Reloading with one bit still pending keeps consecutive codewords gap-free.
  assign load   = nibble_full_q && (bits_left_q <= bits_left_t'(1));
  assign busy   = (bits_left_q != '0);

  hamming74_enc u_enc (
    .nibble (nibble_q),
    .cw     (cw)
  );

  // NOTE: nonblocking assignments here so every register samples pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nibble_q      <= '0;
      cnt_q         <= '0;
      nibble_full_q <= 1'b0;
    end else begin
      if (accept) begin
        if (MSB_FIRST) nibble_q <= {nibble_q[DATA_W-2:0], bus.s_in};
        else           nibble_q <= {bus.s_in, nibble_q[DATA_W-1:1]};
        cnt_q <= cnt_q + 2'd1;
      end
      if (accept && (cnt_q == 2'd3)) nibble_full_q <= 1'b1;
      else if (load)                 nibble_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      bits_left_q <= '0;
    end else if (load) begin
      shreg_q     <= cw;
      bits_left_q <= bits_left_t'(CW_W);
    end else if (busy) begin
      shreg_q     <= {shreg_q[CW_W-2:0], 1'b0};
      bits_left_q <= bits_left_q - bits_left_t'(1);
    end
  end

  assign bus.in_ready  = !nibble_full_q;
  assign bus.out_valid = busy;
  assign bus.s_out     = busy && shreg_q[CW_W-1];
  // bits_left only equals the full width in the cycle right after a load.
  assign bus.cw_start  = (bits_left_q == bits_left_t'(CW_W));

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Self-checking bench for hamming74_serial_encoder: vector table, corner sequences, random traffic vs a queue model.
module tb_hamming74_serial_encoder;

  localparam bit MSB_FIRST = 1'b1;
`ifdef HAMMING_SECDED_EN
  localparam int N = 8;
`else
  localparam int N = 7;
`endif

  typedef struct {
    logic [3:0] nib;
    logic [6:0] cw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hamming74_serial_encoder_if bus ();

  hamming74_serial_encoder #(.MSB_FIRST(MSB_FIRST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: queues of bits still owed to the channel.
  bit         exp_q[$];
  bit         st_q[$];
  bit         pend;
  logic [3:0] pend_nib;
  int         acc_n;
  logic [3:0] acc_nib;
  bit         got_q[$];
  bit         vhist[$];
  int         rdy_low;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Classic positional Hamming: parity at position 2^k covers every position with bit k set.
  function automatic logic [6:0] ref_h74(input logic [3:0] nib);
    bit         pos[8];
    int         dpos[4];
    bit         p;
    logic [6:0] r;
    dpos = '{3, 5, 6, 7};
    for (int j = 0; j < 8; j++) pos[j] = 1'b0;
    for (int i = 0; i < 4; i++) pos[dpos[i]] = nib[3-i];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int j = 1; j < 8; j++)
        if (((j >> k) & 1) == 1 && j != (1 << k)) p ^= pos[j];
      pos[1 << k] = p;
    end
    for (int j = 1; j < 8; j++) r[7-j] = pos[j];
    return r;
  endfunction

  function automatic logic [7:0] exp_word(input logic [6:0] cw7);
`ifdef HAMMING_SECDED_EN
    return {cw7, ^cw7};
`else
    return {1'b0, cw7};
`endif
  endfunction

  function automatic logic [7:0] word_at(input int off);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      if (off + i < got_q.size()) w = {w[6:0], got_q[off+i]};
      else                        w = {w[6:0], 1'b0};
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    st_q.delete();
    pend    = 1'b0;
    acc_n   = 0;
    acc_nib = '0;
  endtask

  task automatic model_edge(input bit v, input bit b);
    bit         accept;
    bit         load;
    bit         dummy;
    logic [6:0] h;
    accept = v && !pend;
    load   = pend && (exp_q.size() <= 1);
    if (exp_q.size() != 0) begin
      dummy = exp_q.pop_front();
      dummy = st_q.pop_front();
    end
    if (load) begin
      h = ref_h74(pend_nib);
      for (int i = 6; i >= 0; i--) begin
        exp_q.push_back(h[i]);
        st_q.push_back(i == 6);
      end
`ifdef HAMMING_SECDED_EN
      exp_q.push_back(^h);
      st_q.push_back(1'b0);
`endif
      pend = 1'b0;
    end
    if (accept) begin
      acc_nib[MSB_FIRST ? 3 - acc_n : acc_n] = b;
      acc_n++;
      if (acc_n == 4) begin
        pend     = 1'b1;
        pend_nib = acc_nib;
        acc_n    = 0;
      end
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (exp_q.size() != 0);
    check($sformatf("c%0d in_ready", cyc),  bus.in_ready,  !pend);
    check($sformatf("c%0d out_valid", cyc), bus.out_valid, ev);
    check($sformatf("c%0d s_out", cyc),     bus.s_out,     ev ? exp_q[0] : 1'b0);
    check($sformatf("c%0d cw_start", cyc),  bus.cw_start,  ev ? st_q[0] : 1'b0);
  endtask

  task automatic cycle(input bit v, input bit b);
    bus.in_valid = v;
    bus.s_in     = b;
    @(posedge clk);
    model_edge(v, b);
    cyc++;
    #1;
    compare();
    if (bus.out_valid === 1'b1) got_q.push_back(bus.s_out);
    vhist.push_back(bus.out_valid === 1'b1);
    if (bus.in_ready === 1'b0) rdy_low++;
  endtask

  // Holds in_valid high with the same bit until the model says it was taken.
  task automatic send_bit(input bit b);
    bit taken;
    bit done;
    done = 1'b0;
    for (int t = 0; t < 24; t++) begin
      taken = !pend;
      cycle(1'b1, b);
      if (taken) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_bit timeout at c%0d", cyc);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 0; i < 4; i++) send_bit(MSB_FIRST ? n[3-i] : n[i]);
  endtask

  vec_t vecs[5];
  int   first_v;
  int   last_v;
  int   gaps;

  initial begin
    vecs[0] = '{nib: 4'b1011, cw: 7'b0110011};
    vecs[1] = '{nib: 4'b0000, cw: 7'b0000000};
    vecs[2] = '{nib: 4'b1111, cw: 7'b1111111};
    vecs[3] = '{nib: 4'b1001, cw: 7'b0011001};
    vecs[4] = '{nib: 4'b0001, cw: 7'b1101001};

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.s_in     = 1'b0;
    model_reset();
    #1;
    check("reset in_ready",  bus.in_ready,  1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset s_out",     bus.s_out,     1'b0);
    check("reset cw_start",  bus.cw_start,  1'b0);
    #13;
    reset = 1'b0;

    // Known vectors, one nibble at a time from an idle serializer.
    foreach (vecs[k]) begin
      got_q.delete();
      send_nib(vecs[k].nib);
      cycle(1'b0, 1'b0);
      check($sformatf("vec%0d first-bit latency cw_start", k), bus.cw_start, 1'b1);
      repeat (N + 2) cycle(1'b0, 1'b0);
      check($sformatf("vec%0d bit count", k), got_q.size(), N);
      check($sformatf("vec%0d word", k), word_at(0), exp_word(vecs[k].cw));
    end

    // Back-to-back codewords with in_valid held high throughout.
    got_q.delete();
    vhist.delete();
    rdy_low = 0;
    send_nib(4'b1011);
    send_nib(4'b1001);
    repeat (2 * N + 4) cycle(1'b0, 1'b0);
    check("b2b bit count", got_q.size(), 2 * N);
    check("b2b word0", word_at(0), exp_word(7'b0110011));
    check("b2b word1", word_at(N), exp_word(7'b0011001));
    first_v = -1;
    last_v  = -1;
    gaps    = 0;
    foreach (vhist[i]) if (vhist[i]) begin
      if (first_v < 0) first_v = i;
      last_v = i;
    end
    if (first_v >= 0)
      for (int i = first_v; i <= last_v; i++) if (!vhist[i]) gaps++;
    check("b2b idle gaps", gaps, 0);
    check("b2b in_ready low cycles", rdy_low, N - 3);

    // Gapped input with junk bits while idle and while the serializer holds off.
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      send_bit(4'b0001 >> (3 - i) & 1);
    end
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      send_bit(4'b1001 >> (3 - i) & 1);
    end
    repeat (2 * N + 4) cycle(1'b0, 1'b0);
    check("gap bit count", got_q.size(), 2 * N);
    check("gap word0", word_at(0), exp_word(7'b1101001));
    check("gap word1", word_at(N), exp_word(7'b0011001));

    // Reset mid-codeword with a partial nibble in flight.
    send_nib(4'b1011);
    repeat (3) cycle(1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst in_ready",  bus.in_ready,  1'b1);
    check("midrst out_valid", bus.out_valid, 1'b0);
    check("midrst s_out",     bus.s_out,     1'b0);
    check("midrst cw_start",  bus.cw_start,  1'b0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    got_q.delete();
    repeat (10) cycle(1'b0, 1'b0);
    check("post-reset silence", got_q.size(), 0);
    send_nib(4'b1001);
    repeat (N + 2) cycle(1'b0, 1'b0);
    check("post-reset word", word_at(0), exp_word(7'b0011001));

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    repeat (2 * N + 4) cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
